// File: rtl/phase_sequencer.sv
// Multi-cycle phase sequencer for the 16-bit SIMPLE-style core: walks each instruction
// through fetch/decode/execute/memory/writeback, handshakes with memory and halts on HLT or stall.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   P1     | fetch: mem_req until mem_ack, IR captured on ack
//   P2     | decode IR into held control registers
//   P3     | execute: branch flags sampled
//   P4     | memory access for LD/ST (or pass-through slot when P4 is not skipped)
//   P5     | writeback and PC update strobes
//   HALT   | stopped by HLT or stall timeout, waiting for start
module phase_sequencer #(
  parameter int STALL_MAX = 15,
  parameter bit SKIP_P4   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_ack,
  input  logic [15:0] ir,
  input  logic        flag_z,
  input  logic        flag_s,
  input  logic        flag_v,
  output logic [2:0]  phase,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        alusrc_sel,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd7
  } state_t;

  // The counter only ever needs to hold STALL_MAX-1 before the timeout fires.
  localparam int SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX);
  localparam bit TO_EN = (STALL_MAX != 0);
  localparam logic [SW-1:0] STALL_LIM = TO_EN ? SW'(STALL_MAX - 1) : '0;

  state_t        r_state, w_next;
  logic [SW-1:0] r_stall;
  logic          r_err;
  logic          r_alusrc, r_wb, r_mem, r_st, r_hlt, r_br_always, r_br_cond, r_taken;
  logic [3:0]    r_alu_op;
  logic [2:0]    r_cc;

  logic          w_alusrc, w_wb, w_mem, w_st, w_hlt, w_br_always, w_br_cond;
  logic [3:0]    w_alu_op;
  logic          w_cond, w_wait, w_timeout, w_start_ok;

  always_comb begin
    w_alusrc    = 1'b0;
    w_alu_op    = 4'h0;
    w_wb        = 1'b0;
    w_mem       = 1'b0;
    w_st        = 1'b0;
    w_hlt       = 1'b0;
    w_br_always = 1'b0;
    w_br_cond   = 1'b0;
    case (ir[15:14])
      2'b11: begin
        w_alu_op = ir[7:4];
        w_alusrc = (ir[7:6] == 2'b10);
        w_hlt    = (ir[7:4] == 4'hF);
        w_wb     = (ir[7:4] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6,
                                    4'h8, 4'h9, 4'hA, 4'hB, 4'hC});
      end
      2'b00: begin
        w_mem    = 1'b1;
        w_alusrc = 1'b1;
        w_wb     = 1'b1;
      end
      2'b01: begin
        w_mem    = 1'b1;
        w_st     = 1'b1;
        w_alusrc = 1'b1;
      end
      default: begin
        case (ir[13:11])
          3'b000: begin
            w_alusrc = 1'b1;
            w_alu_op = 4'h6;
            w_wb     = 1'b1;
          end
          3'b100: begin
            w_alusrc    = 1'b1;
            w_br_always = 1'b1;
          end
          3'b111: begin
            w_alusrc  = 1'b1;
            w_br_cond = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
    case (r_cc)
      3'b000:  w_cond = flag_z;
      3'b001:  w_cond = flag_s ^ flag_v;
      3'b010:  w_cond = flag_z | (flag_s ^ flag_v);
      3'b011:  w_cond = ~flag_z;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_wait     = (r_state == S_P1) || ((r_state == S_P4) && r_mem);
  assign w_timeout  = TO_EN && w_wait && !mem_ack && (r_stall == STALL_LIM);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_P1;
      S_P1: begin
        if (mem_ack)        w_next = S_P2;
        else if (w_timeout) w_next = S_HALT;
      end
      S_P2: w_next = S_P3;
      S_P3: begin
        if (r_hlt)                  w_next = S_HALT;
        else if (r_mem || !SKIP_P4) w_next = S_P4;
        else                        w_next = S_P5;
      end
      S_P4: begin
        if (!r_mem || mem_ack) w_next = S_P5;
        else if (w_timeout)    w_next = S_HALT;
      end
      S_P5:    w_next = S_P1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wait && !mem_ack && !w_timeout) r_stall <= r_stall + 1'b1;
      else                                  r_stall <= '0;
      if (w_timeout)       r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alusrc    <= 1'b0;
      r_alu_op    <= 4'h0;
      r_wb        <= 1'b0;
      r_mem       <= 1'b0;
      r_st        <= 1'b0;
      r_hlt       <= 1'b0;
      r_br_always <= 1'b0;
      r_br_cond   <= 1'b0;
      r_cc        <= 3'b000;
      r_taken     <= 1'b0;
    end else begin
      if (r_state == S_P2) begin
        r_alusrc    <= w_alusrc;
        r_alu_op    <= w_alu_op;
        r_wb        <= w_wb;
        r_mem       <= w_mem;
        r_st        <= w_st;
        r_hlt       <= w_hlt;
        r_br_always <= w_br_always;
        r_br_cond   <= w_br_cond;
        r_cc        <= ir[10:8];
      end
      if (r_state == S_P3) r_taken <= r_br_always | (r_br_cond & w_cond);
    end
  end

  assign phase      = r_state;
  assign mem_req    = w_wait;
  assign mem_we     = (r_state == S_P4) && r_st;
  assign ir_load    = (r_state == S_P1) && mem_ack;
  assign alusrc_sel = r_alusrc;
  assign alu_op     = r_alu_op;
  assign reg_we     = (r_state == S_P5) && r_wb;
  assign pc_we      = (r_state == S_P5);
  assign pc_sel     = (r_state == S_P5) && r_taken;
  assign halted     = (r_state == S_HALT);
  assign err        = r_err;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus random instructions, flags and ack
// delays, checked against an instruction-level model of the expected phase walk and strobes.
module tb_phase_sequencer;

  logic        clk, rst_n, start, mem_ack, flag_z, flag_s, flag_v;
  logic [15:0] ir;
  logic [2:0]  phase;
  logic        mem_req, mem_we, ir_load, alusrc_sel, reg_we, pc_we, pc_sel, halted, err;
  logic [3:0]  alu_op;

  int n_assert = 0;
  int n_fail   = 0;

  phase_sequencer #(.STALL_MAX(15), .SKIP_P4(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ack(mem_ack), .ir(ir),
    .flag_z(flag_z), .flag_s(flag_s), .flag_v(flag_v), .phase(phase),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .alusrc_sel(alusrc_sel),
    .alu_op(alu_op), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         src;
    logic [3:0] alu;
    bit         ctl_known;
    bit         wb;
    bit         mem;
    bit         st;
    bit         hlt;
    bit         taken;
  } exp_t;

  // Instruction-level view of what one instruction must do.
  function automatic exp_t model(logic [15:0] w, bit z, bit s, bit v);
    exp_t e;
    int   cls, op, sub, cc;
    e = '{src: 0, alu: 4'h0, ctl_known: 1, wb: 0, mem: 0, st: 0, hlt: 0, taken: 0};
    cls = int'(w[15:14]);
    op  = int'(w[7:4]);
    sub = int'(w[13:11]);
    cc  = int'(w[10:8]);
    if (cls == 3) begin
      e.alu = w[7:4];
      e.src = (op >= 8 && op <= 11);
      e.hlt = (op == 15);
      e.wb  = (op <= 4) || (op == 6) || (op >= 8 && op <= 12);
      e.ctl_known = !(op == 7 || op == 14 || op == 15);
    end else if (cls <= 1) begin
      e.mem = 1;
      e.st  = (cls == 1);
      e.src = 1;
      e.wb  = (cls == 0);
    end else if (sub == 0) begin
      e.src = 1; e.alu = 4'h6; e.wb = 1;
    end else if (sub == 4) begin
      e.src = 1; e.taken = 1;
    end else begin
      e.ctl_known = 0;
      if (sub == 7) begin
        if (cc == 0)      e.taken = z;
        else if (cc == 1) e.taken = (s != v);
        else if (cc == 2) e.taken = z || (s != v);
        else if (cc == 3) e.taken = !z;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered and left with phase == P1, two time units after the clock edge.
  task automatic run_instr(input logic [15:0] w, input bit z, input bit s, input bit v,
                           input int d1, input int d4, input bit abort_p4);
    exp_t e;
    e = model(w, z, s, v);
    chk("p1_phase", 16'(phase), 16'd1);
    chk("p1_req", 16'(mem_req), 16'd1);
    chk("p1_we", 16'(mem_we), 16'd0);
    mem_ack = 1'b0;
    for (int i = 0; i < d1; i++) begin
      tick();
      chk("p1_wait", 16'(phase), 16'd1);
    end
    mem_ack = 1'b1;
    ir      = w;
    #1;
    chk("ir_load", 16'(ir_load), 16'd1);
    tick();
    mem_ack = 1'b0;
    chk("p2_phase", 16'(phase), 16'd2);
    flag_z = z; flag_s = s; flag_v = v;
    start  = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    chk("p3_phase", 16'(phase), 16'd3);
    chk("p3_pcwe", 16'(pc_we), 16'd0);
    if (e.ctl_known) begin
      chk("p3_src", 16'(alusrc_sel), 16'(e.src));
      chk("p3_alu", 16'(alu_op), 16'(e.alu));
    end
    tick();
    {flag_z, flag_s, flag_v} = 3'($urandom_range(0, 7));
    if (e.hlt) begin
      chk("hlt_phase", 16'(phase), 16'd7);
      chk("hlt_halted", 16'(halted), 16'd1);
      chk("hlt_strobes", 16'({reg_we, pc_we, mem_req}), 16'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_halted", 16'(halted), 16'd0);
      chk("restart_err", 16'(err), 16'd0);
      return;
    end
    if (e.mem) begin
      chk("p4_phase", 16'(phase), 16'd4);
      chk("p4_req", 16'(mem_req), 16'd1);
      chk("p4_we", 16'(mem_we), 16'(e.st));
      if (abort_p4) begin
        rst_n = 1'b0;
        #1;
        chk("rst_phase", 16'(phase), 16'd0);
        chk("rst_req", 16'(mem_req), 16'd0);
        chk("rst_we", 16'(mem_we), 16'd0);
        tick();
        chk("rst_held", 16'({pc_we, reg_we}), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_idle", 16'(phase), 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        return;
      end
      for (int i = 0; i < d4; i++) begin
        tick();
        chk("p4_wait", 16'(phase), 16'd4);
      end
      mem_ack = 1'b1;
      #1;
      chk("p4_noload", 16'(ir_load), 16'd0);
      tick();
      mem_ack = 1'b0;
    end
    chk("p5_phase", 16'(phase), 16'd5);
    chk("p5_pcwe", 16'(pc_we), 16'd1);
    chk("p5_regwe", 16'(reg_we), 16'(e.wb));
    chk("p5_pcsel", 16'(pc_sel), 16'(e.taken));
    chk("p5_req", 16'(mem_req), 16'd0);
    if (e.ctl_known) begin
      chk("p5_src", 16'(alusrc_sel), 16'(e.src));
      chk("p5_alu", 16'(alu_op), 16'(e.alu));
    end
    tick();
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; ir = 16'h0;
    flag_z = 1'b0; flag_s = 1'b0; flag_v = 1'b0;
    #7;
    chk("reset_phase", 16'(phase), 16'd0);
    chk("reset_outs", 16'({mem_req, mem_we, ir_load, alusrc_sel, alu_op, reg_we, pc_we,
                          pc_sel, halted, err}), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_stay", 16'(phase), 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;

    run_instr(16'hC010, 0, 0, 0, 1, 0, 0);   // SUB
    run_instr(16'hC083, 0, 0, 0, 0, 0, 0);   // SLL
    run_instr(16'h0105, 0, 0, 0, 2, 3, 0);   // LD
    run_instr(16'h4105, 0, 0, 0, 0, 1, 0);   // ST
    run_instr(16'hB800, 1, 0, 0, 0, 0, 0);   // BE taken
    run_instr(16'hB800, 0, 0, 0, 0, 0, 0);   // BE not taken
    run_instr(16'hB900, 0, 1, 0, 0, 0, 0);   // BLT taken
    run_instr(16'h8000, 0, 0, 0, 0, 0, 0);   // LI
    run_instr(16'hA000, 0, 0, 0, 0, 0, 0);   // B
    run_instr(16'hC0F0, 0, 0, 0, 0, 0, 0);   // HLT then restart
    run_instr(16'hC050, 0, 0, 0, 0, 0, 0);   // CMP

    // Fetch stall: 15 cycles in P1 without ack, then error halt.
    chk("stall_p1", 16'(phase), 16'd1);
    for (int i = 0; i < 14; i++) tick();
    chk("stall_c15", 16'(phase), 16'd1);
    tick();
    chk("stall_phase", 16'(phase), 16'd7);
    chk("stall_err", 16'(err), 16'd1);
    chk("stall_req", 16'(mem_req), 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stall_clr", 16'(err), 16'd0);
    run_instr(16'hC010, 0, 0, 0, 14, 0, 0);  // ack on cycle 15 wins
    chk("late_ack_err", 16'(err), 16'd0);
    run_instr(16'h0105, 0, 0, 0, 0, 14, 0);  // ack on P4 cycle 15 wins

    for (int n = 0; n < 60; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[13:11] = 3'b111;
      run_instr(w, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 14), $urandom_range(0, 14), 0);
    end

    run_instr(16'h4105, 0, 0, 0, 0, 0, 1);   // reset during ST memory phase
    run_instr(16'hC050, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
